// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester, multiplier and response signals of one shared multiplier.
interface mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH_A = 18,
    parameter int WIDTH_B = 18,
    parameter int WIDTH_P = 36
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*WIDTH_A-1:0] req_a;
    logic [NUM_REQ*WIDTH_B-1:0] req_b;
    logic [WIDTH_A-1:0]         mult_a;
    logic [WIDTH_B-1:0]         mult_b;
    logic                       mult_ce;
    logic [WIDTH_P-1:0]         mult_p;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [WIDTH_P-1:0]         rsp_p;
    logic                       busy;
    modport master (
        output req_valid, req_a, req_b, mult_p,
        input  req_ready, mult_a, mult_b, mult_ce, rsp_valid, rsp_p, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, mult_p,
        output req_ready, mult_a, mult_b, mult_ce, rsp_valid, rsp_p, busy
    );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one free-running pipelined multiplier among NUM_REQ requesters.
// Define MULT_ARB_FIXED_PRI_EN for fixed priority (lowest valid index wins, no pointer).
module mult_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH_A      = 18,
    parameter int WIDTH_B      = 18,
    parameter int WIDTH_P      = 36,
    parameter int MULT_LATENCY = 2
) (
    input logic           clk,
    input logic           rst,
    mult_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    logic                            issue;
    logic                            any_lo;
    logic                            any_hi;
    logic [IW-1:0]                   ptr;
    logic [IW-1:0]                   idx_lo;
    logic [IW-1:0]                   idx_hi;
    logic [IW-1:0]                   grant_idx;
    logic [MULT_LATENCY-1:0]         tag_v;
    logic [MULT_LATENCY-1:0][IW-1:0] tag_i;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [WIDTH_P-1:0]              rsp_p;
`ifdef MULT_ARB_FIXED_PRI_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (issue) ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
`endif
    // Lowest valid index at/above ptr wins; otherwise the lowest valid index (wrap-around).
    always_comb begin
        any_lo = 1'b0;
        any_hi = 1'b0;
        idx_lo = '0;
        idx_hi = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                any_lo = 1'b1;
                idx_lo = IW'(k);
                if (IW'(k) >= ptr) begin
                    any_hi = 1'b1;
                    idx_hi = IW'(k);
                end
            end
        end
        grant_idx = any_hi ? idx_hi : idx_lo;
        issue     = any_lo & ~rst;
    end
    assign bus.req_ready = issue ? NUM_REQ'(1) << grant_idx : '0;
    assign bus.mult_a    = issue ? bus.req_a[grant_idx*WIDTH_A +: WIDTH_A] : '0;
    assign bus.mult_b    = issue ? bus.req_b[grant_idx*WIDTH_B +: WIDTH_B] : '0;
    assign bus.mult_ce   = ~rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v     <= '0;
            rsp_valid <= '0;
            rsp_p     <= '0;
        end else begin
            tag_v[0] <= issue;
            for (int k = 1; k < MULT_LATENCY; k++) tag_v[k] <= tag_v[k-1];
            rsp_valid <= tag_v[MULT_LATENCY-1] ? NUM_REQ'(1) << tag_i[MULT_LATENCY-1] : '0;
            if (tag_v[MULT_LATENCY-1]) rsp_p <= bus.mult_p;
        end
    end
    always_ff @(posedge clk) begin
        tag_i[0] <= grant_idx;
        for (int k = 1; k < MULT_LATENCY; k++) tag_i[k] <= tag_i[k-1];
    end
    assign bus.rsp_valid = rst ? '0 : rsp_valid;
    assign bus.rsp_p     = rst ? '0 : rsp_p;
    assign bus.busy      = ~rst & (|tag_v | |rsp_valid);
endmodule
